qld_div8: RTL and testbench

//  Pipelined approximate signed 8-bit divider in the logarithmic domain; inverse companion of the QLM log multiplier.

---
 rtl/qld_div8.sv | 120 ++++++++++++
 tb/tb_qld_div8.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/qld_div8.sv
// qld_div8: pipelined approximate signed 8-bit divider in the log domain.
// Operands are one's-complement signed; each is reduced to log2 form
// {k, m} (leading-one position plus truncated mantissa), the logs are
// subtracted, and the difference is taken back through a piecewise-linear
// antilog to give a one's-complement signed Q8.8 quotient.
// Three register stages move together on a shared advance enable.
module qld_div8 #(
  parameter int MANT_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] q,
  output logic        div_zero
);

  localparam int LW = 3 + MANT_W;   // {k, m} log width
  localparam int DW = LW + 1;       // signed log difference width

  // leading-one position; an all-zero input yields 0 (flagged separately)
  function automatic logic [2:0] lod(input logic [7:0] a);
    lod = '0;
    for (int b = 0; b < 8; b++)
      if (a[b]) lod = 3'(b);
  endfunction

  // MANT_W bits directly below the leading one, left-aligned, zero-filled
  function automatic logic [MANT_W-1:0] mant(input logic [7:0] a, input logic [2:0] k);
    logic [7:0] s;
    s    = a << (3'd7 - k);
    mant = s[6 -: MANT_W];
  endfunction

  logic [3:1] vld_pipe;
  logic       adv;

  assign adv       = ~vld_pipe[3] | out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe[3];

  // operand magnitudes and their log2 decomposition
  logic [7:0] ax, ay;
  logic [2:0] kx, ky;
  assign ax = x ^ {8{x[7]}};
  assign ay = y ^ {8{y[7]}};
  assign kx = lod(ax);
  assign ky = lod(ay);

  logic [LW-1:0]        s1_lx, s1_ly;
  logic                 s1_sign, s1_zx, s1_zy;
  logic signed [DW-1:0] s2_d;
  logic                 s2_sign, s2_zx, s2_zy;

  // valid shift register; bubbles travel with the data, no collapsing
  always_ff @(posedge clk) begin
    if (rst)
      vld_pipe <= '0;
    else if (adv)
      vld_pipe <= {vld_pipe[2:1], in_valid};
  end

  // stage 1: capture log forms and sign/zero flags on every advance
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_lx   <= {kx, mant(ax, kx)};
      s1_ly   <= {ky, mant(ay, ky)};
      s1_sign <= x[7] ^ y[7];
      s1_zx   <= (ax == 8'd0);
      s1_zy   <= (ay == 8'd0);
    end
  end

  // stage 2: log difference; both logs lie in [0, 8) so DW bits never overflow
  always_ff @(posedge clk) begin
    if (adv) begin
      s2_d    <= $signed({1'b0, s1_lx}) - $signed({1'b0, s1_ly});
      s2_sign <= s1_sign;
      s2_zx   <= s1_zx;
      s2_zy   <= s1_zy;
    end
  end

  // antilog: integer part i in -8..7, so i+8 is just i with its MSB flipped
  logic [3:0]        d_int;
  logic [MANT_W-1:0] d_frac;
  logic [3:0]        sh;
  logic [31:0]       wide;
  logic [15:0]       mag;

  assign d_int  = s2_d[DW-1:MANT_W];
  assign d_frac = s2_d[MANT_W-1:0];
  assign sh     = {~d_int[3], d_int[2:0]};
  assign wide   = 32'({1'b1, d_frac}) << sh;
  assign mag    = wide[MANT_W +: 16];

  // stage 3: output register; divide-by-zero saturates and wins over zero dividend
  always_ff @(posedge clk) begin
    if (rst) begin
      q        <= 16'h0000;
      div_zero <= 1'b0;
    end else if (adv && vld_pipe[2]) begin
      if (s2_zy) begin
        q        <= s2_sign ? 16'h8000 : 16'h7FFF;
        div_zero <= 1'b1;
      end else if (s2_zx) begin
        q        <= 16'h0000;
        div_zero <= 1'b0;
      end else begin
        q        <= mag ^ {16{s2_sign}};
        div_zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qld_div8.sv
// Scoreboard bench for qld_div8: the driver pushes expected results on each
// accepted operand pair, an independent monitor pops and compares on each
// emitted result. Random traffic is checked against a real-valued log model.
`timescale 1ns/1ps
module tb_qld_div8;
  localparam int MW = 4;

  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [7:0]  x = 0, y = 0;
  logic        in_ready, out_valid, div_zero;
  logic [15:0] q;

  qld_div8 #(.MANT_W(MW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0, n_out = 0;
  logic [16:0] sb[$];
  logic [16:0] exp_cur;
  logic        took;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // log2 of a nonzero magnitude, mantissa truncated to MW fraction bits
  function automatic real lg(input int a);
    int  k = 0;
    real m;
    while ((2 ** (k + 1)) <= a) k++;
    m = $floor((real'(a) / (2.0 ** k) - 1.0) * (2.0 ** MW));
    return real'(k) + m / (2.0 ** MW);
  endfunction

  // reference: {q, div_zero}
  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b);
    int   ax, ay, i, mag;
    logic s;
    real  d, f;
    ax = a[7] ? (255 - int'(a)) : int'(a);
    ay = b[7] ? (255 - int'(b)) : int'(b);
    s  = a[7] ^ b[7];
    if (ay == 0) return {(s ? 16'h8000 : 16'h7FFF), 1'b1};
    if (ax == 0) return 17'h0;
    d   = lg(ax) - lg(ay);
    i   = $rtoi($floor(d));
    f   = d - real'(i);
    mag = $rtoi($floor((2.0 ** i) * (1.0 + f) * 256.0));
    return {(s ? ~16'(mag) : 16'(mag)), 1'b0};
  endfunction

  // one clock: record a transfer at negedge, return just after the rising edge
  task automatic tick();
    @(negedge clk);
    took = 0;
    if (!rst && in_valid && in_ready) begin
      sb.push_back(exp_cur);
      took = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [16:0] e);
    x = a; y = b; exp_cur = e; in_valid = 1;
    for (int t = 0; t < 200; t++) begin
      tick();
      if (took) break;
    end
    if (!took) begin n_chk++; n_fail++; $display("FAIL send_timeout: operand never accepted"); end
  endtask

  task automatic drain();
    in_valid = 0; out_ready = 1;
    for (int t = 0; t < 100 && sb.size() != 0; t++) tick();
    chk("drain_empty", sb.size(), 0);
  endtask

  function automatic logic [7:0] rnd();
    case ($urandom % 8)
      0: return 8'h00;
      1: return 8'hFF;
      2: return 8'h80;
      3: return 8'h7F;
      default: return 8'($urandom);
    endcase
  endfunction

  // monitor: every emitted result must match the head of the scoreboard
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (sb.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_out: got q=%0h with nothing outstanding", q);
      end else begin
        e = sb.pop_front();
        chk("q", q, e[16:1]);
        chk("div_zero", div_zero, e[0]);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0]  dx[8] = '{8'd64, 8'd96, 8'd1, 8'hBF, 8'd5, 8'hFA, 8'd0, 8'd0};
  logic [7:0]  dy[8] = '{8'd4, 8'd3, 8'd127, 8'd4, 8'd0, 8'h00, 8'd9, 8'd0};
  logic [16:0] de[8] = '{{16'h1000, 1'b0}, {16'h2000, 1'b0}, {16'h0002, 1'b0}, {16'hEFFF, 1'b0},
                         {16'h7FFF, 1'b1}, {16'h8000, 1'b1}, {16'h0000, 1'b0}, {16'h7FFF, 1'b1}};

  initial begin
    int lat, acc, idx, n, outs0;
    logic [7:0] bx[6], by[6];

    // reset state
    rst = 1;
    repeat (2) tick();
    rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", q, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_in_ready", in_ready, 1);

    // latency of a single op under continuous out_ready
    out_ready = 1;
    send(dx[0], dy[0], de[0]);
    in_valid = 0;
    lat = 0;
    for (int t = 0; t < 10; t++) begin
      lat++;
      @(negedge clk);
      if (out_valid) break;
    end
    @(posedge clk); #1;
    chk("latency", lat, 3);
    drain();

    // directed values, back to back
    for (int i = 0; i < 8; i++) send(dx[i], dy[i], de[i]);
    drain();

    // backpressure: six ops with the sink stalled, then release
    for (int i = 0; i < 6; i++) begin bx[i] = rnd(); by[i] = rnd(); end
    out_ready = 0; acc = 0; idx = 0;
    x = bx[0]; y = by[0]; exp_cur = model(bx[0], by[0]); in_valid = 1;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (took) begin
        acc++; idx++;
        x = bx[idx]; y = by[idx]; exp_cur = model(bx[idx], by[idx]);
      end
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1;
    for (int i = idx; i < 6; i++) send(bx[i], by[i], model(bx[i], by[i]));
    drain();

    // reset with three ops in flight
    out_ready = 0;
    for (int i = 0; i < 3; i++) send(rnd(), rnd(), 17'h0);
    in_valid = 0;
    rst = 1;
    tick();
    rst = 0;
    sb.delete();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_q", q, 0);
    out_ready = 1;
    outs0 = n_out;
    repeat (6) tick();
    chk("midrst_no_stale", n_out - outs0, 0);

    // random traffic against the model
    n = 0;
    for (int c = 0; c < 60000 && n < 10000; c++) begin
      out_ready = ($urandom % 4) != 0;
      if (!in_valid) begin
        x = rnd(); y = rnd();
        if (($urandom % 4) != 0) begin
          in_valid = 1;
          exp_cur = model(x, y);
        end
      end
      tick();
      if (took) begin n++; in_valid = 0; end
    end
    chk("rand_ops", n, 10000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
